// File: rtl/mmio_store_queue.sv
// Captures CPU stores that land in a memory-mapped output window into a FWFT FIFO
// for a valid/ready consumer, and latches a sticky done flag on a store to DONE_ADDR.
module mmio_store_queue #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          WINDOW_WORDS = 256,
    parameter logic [31:0] DONE_ADDR    = 32'h0000_0FFC,
    parameter int          DEPTH        = 8,
    parameter int          DROP_W       = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            MemWrite,
    input  logic [31:0]                     DataAdr,
    input  logic [31:0]                     WriteData,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(WINDOW_WORDS)-1:0] out_idx,
    output logic [31:0]                     out_data,
    output logic [$clog2(DEPTH):0]          level,
    output logic                            full,
    output logic [DROP_W-1:0]               drop_count,
    output logic                            done,
    output logic                            drained
);

    localparam int IDX_W = $clog2(WINDOW_WORDS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = IDX_W + 32;

    // Window bounds carried at 33 bits so a window ending at 4 GiB cannot wrap.
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + 33'(4 * WINDOW_WORDS);

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             in_window;
    logic             hit;
    logic             done_hit;
    logic             pop;
    logic             push;
    logic             drop;
    logic [IDX_W-1:0] idx_in;

    // Store decode: window hit, entry index and done-register strobe.
    assign in_window = ({1'b0, DataAdr} >= WIN_LO) && ({1'b0, DataAdr} < WIN_HI);
    assign hit       = MemWrite && in_window && (DataAdr[1:0] == 2'b00);
    assign done_hit  = MemWrite && (DataAdr == DONE_ADDR);
    assign idx_in    = IDX_W'((DataAdr - BASE_ADDR) >> 2);

    assign pop  = out_valid && out_ready;
    assign push = hit && (!full || pop);
    assign drop = hit && full && !pop;

    // Control state: pointers, occupancy, drop counter and done flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            drop_count <= '0;
            done       <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                level <= level + LVL_W'(1);
            else if (pop && !push)
                level <= level - LVL_W'(1);
            if (drop)     drop_count <= sat_inc(drop_count);
            if (done_hit) done       <= 1'b1;
        end
    end

    // Entry storage is data only; reset discards entries through the pointers.
    always_ff @(posedge clk) begin
        if (push && !reset)
            mem[wr_ptr] <= {idx_in, WriteData};
    end

    // Head presentation: first-word-fall-through from the registered array.
    assign {out_idx, out_data} = mem[rd_ptr];
    assign out_valid           = (level != '0);
    assign full                = (level == LVL_W'(DEPTH));
    assign drained             = done && (level == '0);

endmodule

// File: doc/mmio_store_queue.md
Name: mmio_store_queue

Overview:
- Sits directly downstream of the CPU core's data-memory write port (MemWrite / DataAdr / WriteData).
- Captures CPU stores that fall in a memory-mapped output window into a FIFO, then drains them to a consumer (e.g. frame/pixel writer) over a valid/ready handshake.
- Also latches a sticky "program done" flag when the CPU stores to a dedicated DONE address, so benches and display logic know the CPU has finished its output.

Parameters:
- BASE_ADDR, 32'h0000_1000, byte address of window word 0.
- WINDOW_WORDS, 256, window size in 32-bit words; power of 2.
- DONE_ADDR, 32'h0000_0FFC, byte address of the done register; must lie outside the window.
- DEPTH, 8, FIFO entries; power of 2, ≥2.
- DROP_W, 16, width of the drop counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- MemWrite  in  1  CPU store strobe; one store per cycle when high.
- DataAdr  in  32  CPU store byte address.
- WriteData  in  32  CPU store data.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head this cycle.
- out_idx  out  log2(WINDOW_WORDS)  word index of head entry.
- out_data  out  32  data of head entry.
- level  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- drop_count  out  DROP_W  stores lost because FIFO was full; saturating.
- done  out  1  sticky; set by a store to DONE_ADDR.
- drained  out  1  done && level == 0.

Behaviour:
- Reset: synchronous, sampled on rising clk edge. It clears write/read pointers, level, drop_count and done; queued entries are discarded.
  - Outputs after the reset edge: out_valid=0, full=0, level=0, drop_count=0, done=0, drained=0.
  - out_idx/out_data are don't-care while out_valid=0.
  - Reset mid-stream takes priority over any simultaneous push or pop.
- Window hit requires all of: MemWrite=1, BASE_ADDR ≤ DataAdr < BASE_ADDR+4*WINDOW_WORDS, and DataAdr[1:0]==2'b00.
  - Misaligned or out-of-window stores are ignored silently, with no drop count.
- Entry stored = {idx=(DataAdr-BASE_ADDR)>>2, truncated to log2(WINDOW_WORDS) bits; WriteData}.
- push = hit && (!full || pop).
  - When full, a push is accepted only if a pop happens in the same cycle; level then stays at DEPTH.
- pop = out_valid && out_ready. out_ready is ignored while out_valid=0.
- Level update per cycle: push only → +1; pop only → −1; both → unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Drop: hit && full && !pop increments drop_count by 1, saturating at all-ones. The store is lost.
- FIFO is first-word-fall-through from registered storage:
  - out_valid = (level != 0), a registered-state decode.
  - out_idx/out_data show the head entry combinationally from the storage array.
  - Push-to-visible latency: a store accepted at edge N is visible at the head after edge N if the FIFO was empty. There is no same-cycle bypass from MemWrite to out_valid.
- Ordering is strictly FIFO; no coalescing of repeated stores to the same index.
- Done flag:
  - A store with MemWrite=1 and DataAdr==DONE_ADDR sets done at the next edge, regardless of WriteData.
  - done stays set until reset. It never enters the FIFO and is never dropped.
- drained is combinational from done and level.
- No combinational path from out_ready to out_valid.

Test Plan:
- Reset held 2 cycles, then released → out_valid=0, level=0, drop_count=0, done=0 on the first post-reset cycle.
- Store 0xAABBCCDD to 0x1008 with out_ready=0 → next cycle: out_valid=1, out_idx=2, out_data=0xAABBCCDD, level=1. Raise out_ready for 1 cycle → level=0, out_valid=0.
- Ignored stores: to 0x1009, 0x0FF8 and 0x1400 → level stays 0, drop_count stays 0.
- 10 back-to-back stores to 0x1000..0x1024 (data=i) with out_ready=0 → level=8, full=1, drop_count=2. Then drain with out_ready=1 → indices 0..7, data 0..7 in order, then out_valid=0.
- FIFO full with out_ready=1 and a new store to 0x1020 in the same cycle → level stays 8, drop_count unchanged, that entry appears last.
- Store to 0x0FFC with 3 entries queued → done=1, drained=0. Drain all 3 → drained=1 on the cycle level reaches 0. Assert reset mid-drain in a repeat run → all outputs return to reset values next cycle.
